// File: rtl/rate_tick_sched_if.sv
// Control/status bundle of the tick scheduler: run gate, rate-change request/acknowledge,
// the decade strobes and the selected sample strobe.
interface rate_tick_sched_if #(
  parameter int STAGES = 8,
  parameter int SEL_W  = 3
);
  // Handshake: the requester raises sel_req with sel_val for one cycle while busy=0 and
  // sel_ack=0. A legal request raises busy from the next cycle until the switch point;
  // sel_ack then pulses for exactly one cycle. An illegal index pulses sel_err instead.
  // Requests seen while busy or during the sel_ack cycle are dropped.
  logic              run;
  logic              sel_req;
  logic [SEL_W-1:0]  sel_val;
  logic              sel_ack;
  logic              sel_err;
  logic              busy;
  logic [SEL_W-1:0]  cur_sel;
  logic [STAGES-1:0] tick_vec;
  logic              sample_tick;
  logic [1:0]        fsm_state;

  modport master (
    output run, sel_req, sel_val,
    input  sel_ack, sel_err, busy, cur_sel, tick_vec, sample_tick, fsm_state
  );

  modport slave (
    input  run, sel_req, sel_val,
    output sel_ack, sel_err, busy, cur_sel, tick_vec, sample_tick, fsm_state
  );
endinterface

// File: rtl/rate_tick_sched.sv
// Cascaded decade counters producing one-cycle strobes at clk/10^(k+1), plus a selectable
// sample strobe whose rate changes only on a tick common to the old and new rates.
module rate_tick_sched #(
  parameter int                STAGES  = 8,
  parameter int                SEL_W   = 3,
  parameter logic [SEL_W-1:0]  SEL_RST = '0
) (
  input logic              clk,
  input logic              rst_n,
  rate_tick_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt [STAGES];
  logic [STAGES-1:0] inc;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] tick_q;
  logic [SEL_W-1:0]  cur_q;
  logic [SEL_W-1:0]  new_sel;
  logic [SEL_W-1:0]  tgt;
  logic              busy_q;
  logic              ack_q;
  logic              err_q;
  logic              sample_c;
  logic              tgt_hit;

  // Ripple-carry enable chain: stage k advances when every lower stage is at 9.
  always_comb begin
    logic carry;
    inc   = '0;
    adv   = '0;
    carry = bus.run;
    for (int k = 0; k < STAGES; k++) begin
      inc[k] = carry;
      carry  = carry & (cnt[k] == 4'd9);
      adv[k] = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) cnt[k] <= '0;
      tick_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (inc[k]) cnt[k] <= (cnt[k] == 4'd9) ? 4'd0 : cnt[k] + 4'd1;
      end
      tick_q <= adv;
    end
  end

  // The slower of old/new rate ticks only where the faster one also ticks, so switching
  // there never shortens or stretches a sample period.
  assign tgt = (cur_q > new_sel) ? cur_q : new_sel;

  always_comb begin
    sample_c = 1'b0;
    tgt_hit  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (int'(cur_q) == k) sample_c = tick_q[k];
      if (int'(tgt) == k)   tgt_hit  = tick_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_q   <= SEL_RST;
      new_sel <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sel_req) begin
            if (int'(bus.sel_val) < STAGES) begin
              new_sel <= bus.sel_val;
              busy_q  <= 1'b1;
              state   <= PEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PEND: begin
          if (tgt_hit) begin
            cur_q  <= new_sel;
            busy_q <= 1'b0;
            ack_q  <= 1'b1;
            state  <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tick_vec    = tick_q;
  assign bus.sample_tick = sample_c;
  assign bus.cur_sel     = cur_q;
  assign bus.busy        = busy_q;
  assign bus.sel_ack     = ack_q;
  assign bus.sel_err     = err_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_rate_tick_sched.sv
// Bench for rate_tick_sched: a cycle-level behavioural model (tick times from the run-cycle
// count, rate changes from the handshake rules) compared against the DUT every cycle.
module tb_rate_tick_sched;
  localparam int STAGES = 4;
  localparam int SEL_W  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rate_tick_sched_if #(.STAGES(STAGES), .SEL_W(SEL_W)) bus ();

  rate_tick_sched #(.STAGES(STAGES), .SEL_W(SEL_W), .SEL_RST(3'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Model state: what the outputs must be after the most recent clock edge.
  longint            phase;
  int                cyc;
  logic [STAGES-1:0] m_tick;
  int                m_cur, m_new;
  bit                m_busy, m_ack, m_err;

  int first_t0 = -1, first_t2 = -1, first_t3 = -1;
  int ack1_cyc = -1, samp_after_ack = -1;

  function automatic longint p10(input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    phase  = 0;
    cyc    = 0;
    m_tick = '0;
    m_cur  = 0;
    m_new  = 0;
    m_busy = 0;
    m_ack  = 0;
    m_err  = 0;
  endtask

  // Inputs sampled at the coming edge are stable here; predict the post-edge outputs.
  task automatic model_advance();
    logic [STAGES-1:0] nt;
    int tgt;
    for (int k = 0; k < STAGES; k++)
      nt[k] = bus.run && (((phase + 1) % p10(k + 1)) == 0);
    if (bus.run) phase++;
    m_err = 0;
    if (m_ack) begin
      m_ack = 0;
    end else if (m_busy) begin
      tgt = (m_cur > m_new) ? m_cur : m_new;
      if (m_tick[tgt]) begin
        m_cur  = m_new;
        m_busy = 0;
        m_ack  = 1;
      end
    end else if (bus.sel_req) begin
      if (int'(bus.sel_val) < STAGES) begin
        m_new  = int'(bus.sel_val);
        m_busy = 1;
      end else begin
        m_err = 1;
      end
    end
    m_tick = nt;
    cyc++;
  endtask

  // Compare process: check on the falling edge, then predict the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("tick_vec",    bus.tick_vec,    m_tick);
      chk("sample_tick", bus.sample_tick, m_tick[m_cur]);
      chk("cur_sel",     bus.cur_sel,     m_cur);
      chk("busy",        bus.busy,        m_busy);
      chk("sel_ack",     bus.sel_ack,     m_ack);
      chk("sel_err",     bus.sel_err,     m_err);
      if (rst_n) begin
        if (m_tick[0] && first_t0 < 0) first_t0 = cyc;
        if (m_tick[2] && first_t2 < 0) first_t2 = cyc;
        if (m_tick[3] && first_t3 < 0) first_t3 = cyc;
        if (m_ack && exp_q.size() > 0) chk("ack_cycle", cyc, exp_q.pop_front());
        if (m_ack && ack1_cyc < 0) ack1_cyc = cyc;
        if (ack1_cyc >= 0 && samp_after_ack < 0 && cyc > ack1_cyc && m_tick[m_cur])
          samp_after_ack = cyc;
      end
      if (rst_n) model_advance();
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic request(input int v);
    logic [31:0] vv;
    vv = v;
    bus.sel_req = 1'b1;
    bus.sel_val = vv[SEL_W-1:0];
    cycles(1);
    bus.sel_req = 1'b0;
  endtask

  task automatic wait_ack(input int bound);
    int i = 0;
    while (!bus.sel_ack && i < bound) begin
      cycles(1);
      i++;
    end
    chk("ack_seen", bus.sel_ack, 1'b1);
  endtask

  initial begin
    bus.run     = 1'b0;
    bus.sel_req = 1'b0;
    bus.sel_val = '0;
    rst_n       = 1'b0;
    exp_q.push_back(32'd1001);
    exp_q.push_back(32'd3001);
    cycles(3);
    rst_n   = 1'b1;
    bus.run = 1'b1;

    // slow down to stage 2, request sampled at edge 37; a second request while pending
    cycles(36);
    request(2);
    cycles(100);
    request(3);
    cycles(1961);
    // back to stage 0 at edge 2100: switch on the tick_vec[2] at 3000
    request(0);
    cycles(1000);

    // illegal indices, then a legal change with an ignored request during PEND
    request(4);
    cycles(2);
    request(7);
    cycles(2);
    request(1);
    cycles(3);
    request(3);
    wait_ack(500);
    cycles(3);
    chk("cur_after_ignore", m_cur, 32'd1);

    for (int i = 0; i < 20000 && cyc < 10050; i++) cycles(1);

    // pause mid-count, then resume with phase intact
    bus.run = 1'b0;
    cycles(55);
    bus.run = 1'b1;
    cycles(300);

    // reset while a change is pending
    request(3);
    cycles(20);
    chk("busy_before_rst", bus.busy, 1'b1);
    rst_n = 1'b0;
    cycles(2);
    chk("cur_sel_in_rst", bus.cur_sel, 3'd0);
    chk("busy_in_rst", bus.busy, 1'b0);
    rst_n = 1'b1;
    cycles(200);

    // randomized run gating and requests, including illegal indices
    for (int i = 0; i < 20000; i++) begin
      bus.run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 199) == 0) begin
        bus.sel_req = 1'b1;
        bus.sel_val = 3'($urandom_range(0, 7));
      end else begin
        bus.sel_req = 1'b0;
      end
      cycles(1);
    end
    bus.sel_req = 1'b0;
    cycles(5);

    chk("first_tick0", first_t0, 32'd10);
    chk("first_tick2", first_t2, 32'd1000);
    chk("first_tick3", first_t3, 32'd10000);
    chk("sample_after_ack", samp_after_ack, 32'd2000);
    chk("acks_pending", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
